// File: rtl/elastic_pkg.sv
// Shared constants, types and helpers for the elastic valid/ready pipeline.
package elastic_pkg;

    // Largest supported number of register stages.
    localparam int MAX_DEPTH = 16;

    // Per-stage next-state decode.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } stage_ctrl_t;

    // Width needed to count 0..depth valid stages.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic register stage: a valid bit plus a data word.
// The stage can load whenever it is empty or its downstream neighbour
// is loading, which is what lets bubbles collapse under backpressure.
module elastic_stage
    import elastic_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;
    stage_ctrl_t      ctrl_s;

    assign ready = ~valid_r | down_ready;
    assign valid = valid_r;
    assign data  = data_r;

    // Decode what this stage does on the next edge; flush wins over loading.
    always_comb begin
        ctrl_s = HOLD;
        if (flush) begin
            ctrl_s = CLEAR;
        end else if (ready) begin
            ctrl_s = LOAD;
        end else begin
            ctrl_s = HOLD;
        end
    end

    // Stage register; data only moves when the upstream word is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
        end else begin
            case (ctrl_s)
                CLEAR: valid_r <= 1'b0;
                LOAD: begin
                    valid_r <= up_valid;
                    if (up_valid) begin
                        data_r <= up_data;
                    end
                end
                HOLD:    valid_r <= valid_r;
                default: valid_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready delay line of DEPTH stages with flush and occupancy.
// Optional macro ELASTIC_PIPELINE_SKID_EN inserts a 2-entry skid buffer
// ahead of stage 0 so in_ready comes from a register (latency DEPTH+1).
module elastic_pipeline
    import elastic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
`ifdef ELASTIC_PIPELINE_SKID_EN
    parameter int CNT_W = $clog2(DEPTH + 3)
`else
    parameter int CNT_W = cnt_width(DEPTH)
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic             stage_valid_s [DEPTH];
    logic [WIDTH-1:0] stage_data_s  [DEPTH];
    logic             stage_ready_s [DEPTH];
    logic             down_ready_s  [DEPTH];
    logic             up_valid_s    [DEPTH];
    logic [WIDTH-1:0] up_data_s     [DEPTH];
    logic             head_valid_s;
    logic [WIDTH-1:0] head_data_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic [CNT_W-1:0] occupancy_r;

`ifdef ELASTIC_PIPELINE_SKID_EN
    logic [WIDTH-1:0] skid_data_r   [2];
    logic [WIDTH-1:0] skid_data_n_s [2];
    logic [1:0]       skid_cnt_r;
    logic [1:0]       skid_cnt_n_s;
    logic [1:0]       skid_cnt_pop_s;
    logic             skid_ready_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready     = skid_ready_r & ~flush;
    assign head_valid_s = (skid_cnt_r != 2'd0);
    assign head_data_s  = skid_data_r[0];
    assign push_s       = in_valid & in_ready;
    assign pop_s        = head_valid_s & stage_ready_s[0];
    assign skid_cnt_pop_s = skid_cnt_r - {1'b0, pop_s};

    // Next skid contents: entry 0 is the oldest, a pop shifts entry 1 down.
    always_comb begin
        skid_data_n_s = skid_data_r;
        skid_cnt_n_s  = skid_cnt_r;
        if (flush) begin
            skid_cnt_n_s = 2'd0;
        end else begin
            if (pop_s) begin
                skid_data_n_s[0] = skid_data_r[1];
            end else begin
                skid_data_n_s[0] = skid_data_r[0];
            end
            if (push_s) begin
                if (skid_cnt_pop_s == 2'd0) begin
                    skid_data_n_s[0] = in_data;
                end else begin
                    skid_data_n_s[1] = in_data;
                end
            end else begin
                skid_data_n_s[1] = skid_data_r[1];
            end
            skid_cnt_n_s = skid_cnt_pop_s + {1'b0, push_s};
        end
    end

    // Skid storage and the registered ready that decouples out_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_cnt_r     <= 2'd0;
            skid_ready_r   <= 1'b1;
            skid_data_r[0] <= {WIDTH{1'b0}};
            skid_data_r[1] <= {WIDTH{1'b0}};
        end else begin
            skid_cnt_r   <= skid_cnt_n_s;
            skid_ready_r <= (skid_cnt_n_s < 2'd2);
            skid_data_r  <= skid_data_n_s;
        end
    end
`else
    assign in_ready     = stage_ready_s[0] & ~flush;
    assign head_valid_s = in_valid;
    assign head_data_s  = in_data;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == DEPTH - 1) begin : g_last
                assign down_ready_s[gi] = out_ready;
            end else begin : g_mid
                assign down_ready_s[gi] = stage_ready_s[gi+1];
            end
            if (gi == 0) begin : g_first
                assign up_valid_s[gi] = head_valid_s;
                assign up_data_s[gi]  = head_data_s;
            end else begin : g_inner
                assign up_valid_s[gi] = stage_valid_s[gi-1];
                assign up_data_s[gi]  = stage_data_s[gi-1];
            end
            elastic_stage #(.WIDTH(WIDTH)) u_stage (
                .clock      (clock),
                .reset      (reset),
                .flush      (flush),
                .up_valid   (up_valid_s[gi]),
                .up_data    (up_data_s[gi]),
                .down_ready (down_ready_s[gi]),
                .ready      (stage_ready_s[gi]),
                .valid      (stage_valid_s[gi]),
                .data       (stage_data_s[gi])
            );
        end
    endgenerate

    assign out_valid  = stage_valid_s[DEPTH-1];
    assign out_data   = stage_data_s[DEPTH-1];
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;
    assign occupancy  = occupancy_r;

    // Occupancy tracks accepted minus consumed items; flush empties everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            occupancy_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            occupancy_r <= {CNT_W{1'b0}};
        end else begin
            occupancy_r <= occupancy_r + CNT_W'(in_fire_s) - CNT_W'(out_fire_s);
        end
    end

endmodule

// File: tb/tb_elastic_pipeline.sv
// Self-checking bench for elastic_pipeline: directed scenarios on a DEPTH=4
// instance plus a randomized soak of DEPTH=4/1/8 instances against an
// item-position queue model.
module tb_elastic_pipeline;

`ifdef ELASTIC_PIPELINE_SKID_EN
    localparam int EXTRA = 2;
    localparam int LADD  = 1;
    localparam bit SKID  = 1'b1;
`else
    localparam int EXTRA = 0;
    localparam int LADD  = 0;
    localparam bit SKID  = 1'b0;
`endif
    localparam int CW0 = $clog2(4 + 1 + EXTRA);
    localparam int CW1 = $clog2(1 + 1 + EXTRA);
    localparam int CW2 = $clog2(8 + 1 + EXTRA);
    localparam int DEP [3] = '{4, 1, 8};
    localparam int LAT = 4 + LADD;
    localparam int CAP = 4 + EXTRA;

    logic clock;
    logic reset;
    logic iv [3];
    logic [31:0] id [3];
    logic ordy [3];
    logic fl [3];
    logic irdy [3];
    logic ov [3];
    logic [31:0] od [3];
    logic [CW0-1:0] occ0;
    logic [CW1-1:0] occ1;
    logic [CW2-1:0] occ2;
    logic [7:0] occ_v [3];

    int checks = 0;
    int errors = 0;

    // Reference model: queue of in-flight items, oldest first, with stage position
    // (-1 means waiting in the skid buffer).
    logic [31:0] m_data [3][16];
    int          m_pos  [3][16];
    bit          m_mv   [3][16];
    int          m_cnt  [3];
    bit          e_ready [3];
    bit          e_valid [3];
    logic [31:0] e_data  [3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        occ_v[0] = 8'(occ0);
        occ_v[1] = 8'(occ1);
        occ_v[2] = 8'(occ2);
    end

    elastic_pipeline #(.WIDTH(32), .DEPTH(4)) u_dut0 (
        .clock(clock), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .occupancy(occ0));
    elastic_pipeline #(.WIDTH(32), .DEPTH(1)) u_dut1 (
        .clock(clock), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .occupancy(occ1));
    elastic_pipeline #(.WIDTH(32), .DEPTH(8)) u_dut2 (
        .clock(clock), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .occupancy(occ2));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; id[i] = 32'h0; ordy[i] = 1'b0; fl[i] = 1'b0;
        end
    endtask

    task automatic model_eval(input int i);
        int top;
        int skidn;
        top = DEP[i] - 1;
        skidn = 0;
        for (int j = 0; j < m_cnt[i]; j++) begin
            if (m_pos[i][j] < 0) skidn++;
            if (j == 0) m_mv[i][j] = (m_pos[i][j] < top) || (ordy[i] == 1'b1);
            else if (m_pos[i][j] < 0 && m_pos[i][j-1] < 0) m_mv[i][j] = 1'b0;
            else m_mv[i][j] = (m_pos[i][j] + 1 < m_pos[i][j-1]) || m_mv[i][j-1];
        end
        e_valid[i] = (m_cnt[i] > 0) && (m_pos[i][0] == top);
        e_data[i]  = m_data[i][0];
        if (SKID) e_ready[i] = !fl[i] && (skidn < 2);
        else e_ready[i] = !fl[i] && (m_cnt[i] == 0 || m_pos[i][m_cnt[i]-1] > 0 || m_mv[i][m_cnt[i]-1]);
    endtask

    task automatic model_advance(input int i);
        int n;
        int top;
        top = DEP[i] - 1;
        n = 0;
        if (reset || fl[i]) begin
            m_cnt[i] = 0;
        end else begin
            for (int j = 0; j < m_cnt[i]; j++) begin
                if (!(m_mv[i][j] && j == 0 && m_pos[i][j] == top)) begin
                    m_data[i][n] = m_data[i][j];
                    m_pos[i][n]  = m_pos[i][j] + (m_mv[i][j] ? 1 : 0);
                    n++;
                end
            end
            if (iv[i] && e_ready[i]) begin
                m_data[i][n] = id[i];
                m_pos[i][n]  = SKID ? -1 : 0;
                n++;
            end
            m_cnt[i] = n;
        end
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #2;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", ov[0]); end
        checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", irdy[0]); end
        checks++; if (od[0] !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", od[0]); end
        checks++; if (occ_v[0] !== 8'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occ_v[0]); end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        int eo;
        int cons;
        words[0] = 32'hDEADBEEF; words[1] = 32'h12345678;
        words[2] = 32'h98765432; words[3] = 32'hCAFEBABE;
        ordy[0] = 1'b1;
        for (int t = 0; t < LAT + 6; t++) begin
            iv[0] = (t < 4);
            id[0] = (t < 4) ? words[t] : 32'h0;
            #2;
            if (t < 4) begin
                checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready t=%0d got %b exp 1", t, irdy[0]); end
            end
            checks++;
            if (ov[0] !== ((t >= LAT) && (t < LAT + 4))) begin
                errors++; $display("FAIL stream_out_valid t=%0d got %b", t, ov[0]);
            end
            if (t >= LAT && t < LAT + 4) begin
                checks++; if (od[0] !== words[t-LAT]) begin errors++; $display("FAIL stream_out_data t=%0d got %h exp %h", t, od[0], words[t-LAT]); end
            end
            cons = (t - LAT < 0) ? 0 : ((t - LAT > 4) ? 4 : t - LAT);
            eo = ((t < 4) ? t : 4) - cons;
            checks++; if (occ_v[0] !== 8'(eo)) begin errors++; $display("FAIL stream_occupancy t=%0d got %0d exp %0d", t, occ_v[0], eo); end
            @(posedge clock); #1;
        end
        idle_all();
    endtask

    task automatic test_backpressure();
        int got;
        ordy[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            iv[0] = 1'b1;
            id[0] = 32'hB000_0000 + 32'(t);
            #2;
            checks++; if (irdy[0] !== (t < CAP)) begin errors++; $display("FAIL bp_in_ready t=%0d got %b exp %b", t, irdy[0], (t < CAP)); end
            if (t >= LAT) begin
                checks++;
                if (ov[0] !== 1'b1 || od[0] !== 32'hB000_0000) begin
                    errors++; $display("FAIL bp_hold t=%0d got %b/%h exp 1/b0000000", t, ov[0], od[0]);
                end
            end
            @(posedge clock); #1;
        end
        checks++; if (occ_v[0] !== 8'(CAP)) begin errors++; $display("FAIL bp_occupancy got %0d exp %0d", occ_v[0], CAP); end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        got = 0;
        for (int t = 0; t < CAP + LAT + 4; t++) begin
            #2;
            if (ov[0] === 1'b1) begin
                checks++; if (od[0] !== 32'hB000_0000 + 32'(got)) begin errors++; $display("FAIL bp_drain_order got %h exp %h", od[0], 32'hB000_0000 + 32'(got)); end
                got++;
            end
            @(posedge clock); #1;
        end
        checks++; if (got !== CAP) begin errors++; $display("FAIL bp_drain_count got %0d exp %0d", got, CAP); end
        checks++; if (occ_v[0] !== 8'd0) begin errors++; $display("FAIL bp_drain_occupancy got %0d exp 0", occ_v[0]); end
        idle_all();
    endtask

    task automatic test_bubble();
        ordy[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            iv[0] = (t == 0 || t == 4);
            id[0] = (t == 0) ? 32'h1111_0001 : 32'h2222_0002;
            #2;
            checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL bubble_in_ready t=%0d got %b exp 1", t, irdy[0]); end
            @(posedge clock); #1;
        end
        iv[0] = 1'b0;
        #2;
        checks++; if (occ_v[0] !== 8'd2) begin errors++; $display("FAIL bubble_occupancy got %0d exp 2", occ_v[0]); end
        ordy[0] = 1'b1;
        #1;
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h1111_0001) begin errors++; $display("FAIL bubble_first got %b/%h exp 1/11110001", ov[0], od[0]); end
        @(posedge clock); #3;
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'h2222_0002) begin errors++; $display("FAIL bubble_packed got %b/%h exp 1/22220002", ov[0], od[0]); end
        @(posedge clock); #3;
        checks++; if (ov[0] !== 1'b0 || occ_v[0] !== 8'd0) begin errors++; $display("FAIL bubble_empty got %b/%0d exp 0/0", ov[0], occ_v[0]); end
        idle_all();
        tick();
    endtask

    task automatic test_flush();
        ordy[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
            iv[0] = (t < 4);
            id[0] = 32'hA0 + 32'(t);
            @(posedge clock); #1;
        end
        fl[0] = 1'b1; ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'hEE;
        #2;
        checks++; if (irdy[0] !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", irdy[0]); end
        checks++; if (ov[0] !== 1'b1 || od[0] !== 32'hA0) begin errors++; $display("FAIL flush_consume got %b/%h exp 1/a0", ov[0], od[0]); end
        @(posedge clock); #1;
        fl[0] = 1'b0; iv[0] = 1'b0;
        #2;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", ov[0]); end
        checks++; if (occ_v[0] !== 8'd0) begin errors++; $display("FAIL flush_occupancy got %0d exp 0", occ_v[0]); end
        for (int t = 0; t < LAT + 2; t++) begin
            @(posedge clock); #3;
            checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_no_accept t=%0d got %b exp 0", t, ov[0]); end
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid();
        ordy[0] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            iv[0] = 1'b1; id[0] = 32'hC0 + 32'(t);
            @(posedge clock); #1;
        end
        iv[0] = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #2;
        checks++; if (ov[0] !== 1'b0 || od[0] !== 32'h0) begin errors++; $display("FAIL midreset_out got %b/%h exp 0/0", ov[0], od[0]); end
        checks++; if (occ_v[0] !== 8'd0) begin errors++; $display("FAIL midreset_occupancy got %0d exp 0", occ_v[0]); end
        checks++; if (irdy[0] !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b exp 1", irdy[0]); end
        for (int t = 0; t <= LAT + 2; t++) begin
            iv[0] = (t == 0); id[0] = 32'h55;
            #1;
            checks++; if (ov[0] !== (t == LAT)) begin errors++; $display("FAIL midreset_latency t=%0d got %b", t, ov[0]); end
            if (t == LAT) begin
                checks++; if (od[0] !== 32'h55) begin errors++; $display("FAIL midreset_data got %h exp 55", od[0]); end
            end
            @(posedge clock); #3;
        end
        idle_all();
        tick();
    endtask

    task automatic test_soak();
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < 3; i++) begin
                iv[i]   = 1'($urandom_range(0, 1));
                id[i]   = $urandom;
                ordy[i] = (c < 500) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
                fl[i]   = ($urandom_range(0, 63) == 0);
            end
            #2;
            for (int i = 0; i < 3; i++) begin
                model_eval(i);
                checks++; if (irdy[i] !== e_ready[i]) begin errors++; $display("FAIL soak_in_ready inst=%0d c=%0d got %b exp %b", i, c, irdy[i], e_ready[i]); end
                checks++; if (ov[i] !== e_valid[i]) begin errors++; $display("FAIL soak_out_valid inst=%0d c=%0d got %b exp %b", i, c, ov[i], e_valid[i]); end
                if (e_valid[i]) begin
                    checks++; if (od[i] !== e_data[i]) begin errors++; $display("FAIL soak_out_data inst=%0d c=%0d got %h exp %h", i, c, od[i], e_data[i]); end
                end
                checks++; if (occ_v[i] !== 8'(m_cnt[i])) begin errors++; $display("FAIL soak_occupancy inst=%0d c=%0d got %0d exp %0d", i, c, occ_v[i], m_cnt[i]); end
            end
            @(posedge clock);
            for (int i = 0; i < 3; i++) model_advance(i);
            #1;
        end
        idle_all();
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_reset_mid();
        test_soak();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
